// File: rtl/wash_cycle_sequencer.sv
// Washer program sequencer: fill -> wash -> drain -> N x (fill -> rinse -> drain) -> spin,
// with pause, door interlock and fill/drain timeout faults.
module wash_cycle_sequencer #(
    parameter int TICK_DIV      = 1000,
    parameter int RINSE_TICKS   = 15,
    parameter int FILL_TIMEOUT  = 100,
    parameter int DRAIN_TIMEOUT = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       fault_ack,
    input  logic       door_close,
    input  logic [1:0] prog_sel,
    input  logic       water_full,
    input  logic       water_empty,
    output logic       fill_valve,
    output logic       motor_on,
    output logic       drain_valve,
    output logic       door_lock,
    output logic       done,
    output logic       fault,
    output logic [2:0] phase,
    output logic [1:0] rinse_cnt
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int TW = 16;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] FILL_LAST  = TW'(FILL_TIMEOUT - 1);
    localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_TIMEOUT - 1);
    localparam logic [TW-1:0] RINSE_LEN  = TW'(RINSE_TICKS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL    = 3'd1,
        S_AGITATE = 3'd2,
        S_DRAIN   = 3'd3,
        S_SPIN    = 3'd4,
        S_DONE    = 3'd5,
        S_PAUSED  = 3'd6,
        S_FAULT   = 3'd7
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    state_t          r_ret;
    logic [1:0]      r_prog;
    logic [1:0]      r_rinse;
    logic [PW-1:0]   r_presc;
    logic [TW-1:0]   r_tcnt;

    logic [TW-1:0]   w_wash_len;
    logic [TW-1:0]   w_spin_len;
    logic [1:0]      w_num_rinse;
    logic [TW-1:0]   w_agi_len;
    logic            w_tick;
    logic            w_fill_to;
    logic            w_drain_to;
    logic            w_agi_end;
    logic            w_spin_end;
    logic            w_entry;
    logic            w_active;

    logic            w_fill, w_motor, w_drain, w_lock, w_done, w_fault;

    // Per-program durations selected from the latched program
    always_comb begin
        w_wash_len  = 16'd60;
        w_spin_len  = 16'd30;
        w_num_rinse = 2'd3;
        case (r_prog)
            2'd0: begin w_wash_len = 16'd20; w_spin_len = 16'd10; w_num_rinse = 2'd1; end
            2'd1: begin w_wash_len = 16'd40; w_spin_len = 16'd20; w_num_rinse = 2'd2; end
            default: ;
        endcase
    end

    assign w_tick     = (r_presc == PRESC_LAST);
    assign w_agi_len  = (r_rinse == 2'd0) ? w_wash_len : RINSE_LEN;
    assign w_fill_to  = w_tick && (r_tcnt == FILL_LAST);
    assign w_drain_to = w_tick && (r_tcnt == DRAIN_LAST);
    assign w_agi_end  = w_tick && (r_tcnt == w_agi_len - 16'd1);
    assign w_spin_end = w_tick && (r_tcnt == w_spin_len - 16'd1);
    assign w_active   = (r_state == S_FILL) || (r_state == S_AGITATE) ||
                        (r_state == S_DRAIN) || (r_state == S_SPIN);
    // Moving into or out of PAUSED is not a state entry: counts are kept
    assign w_entry    = (w_state_next != r_state) && (r_state != S_PAUSED) &&
                        (w_state_next != S_PAUSED);

    // Next-state logic; door fault > timeout > completion > pause
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (start && door_close && (prog_sel != 2'd3)) w_state_next = S_FILL;
            S_FILL: begin
                if (!door_close)     w_state_next = S_FAULT;
                else if (w_fill_to)  w_state_next = S_FAULT;
                else if (water_full) w_state_next = S_AGITATE;
                else if (pause)      w_state_next = S_PAUSED;
            end
            S_AGITATE: begin
                if (!door_close)     w_state_next = S_FAULT;
                else if (w_agi_end)  w_state_next = S_DRAIN;
                else if (pause)      w_state_next = S_PAUSED;
            end
            S_DRAIN: begin
                if (!door_close)      w_state_next = S_FAULT;
                else if (w_drain_to)  w_state_next = S_FAULT;
                else if (water_empty) w_state_next = (r_rinse < w_num_rinse) ? S_FILL : S_SPIN;
                else if (pause)       w_state_next = S_PAUSED;
            end
            S_SPIN: begin
                if (!door_close)     w_state_next = S_FAULT;
                else if (w_spin_end) w_state_next = S_DONE;
                else if (pause)      w_state_next = S_PAUSED;
            end
            S_DONE:    w_state_next = S_IDLE;
            S_PAUSED: begin
                if (!door_close)     w_state_next = S_FAULT;
                else if (!pause)     w_state_next = r_ret;
            end
            S_FAULT:   if (fault_ack) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // State register plus program latch, return state and rinse count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ret   <= S_IDLE;
            r_prog  <= '0;
            r_rinse <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == S_PAUSED && r_state != S_PAUSED)
                r_ret <= r_state;
            if (r_state == S_IDLE && w_state_next == S_FILL) begin
                r_prog  <= prog_sel;
                r_rinse <= '0;
            end else if (r_state == S_DRAIN && w_state_next == S_FILL) begin
                r_rinse <= r_rinse + 2'd1;
            end
        end
    end

    // Prescaler and tick counter: cleared on entry, advance only while a phase is active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_tcnt  <= '0;
        end else if (w_entry) begin
            r_presc <= '0;
            r_tcnt  <= '0;
        end else if (w_active) begin
            if (w_tick) begin
                r_presc <= '0;
                r_tcnt  <= r_tcnt + 16'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // Output decode of the next state so outputs register alongside the state
    always_comb begin
        w_fill  = (w_state_next == S_FILL);
        w_motor = (w_state_next == S_AGITATE) || (w_state_next == S_SPIN);
        w_drain = (w_state_next == S_DRAIN) || (w_state_next == S_SPIN);
        w_lock  = (w_state_next != S_IDLE) && (w_state_next != S_DONE);
        w_done  = (w_state_next == S_DONE);
        w_fault = (w_state_next == S_FAULT);
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_valve  <= 1'b0;
            motor_on    <= 1'b0;
            drain_valve <= 1'b0;
            door_lock   <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            fill_valve  <= w_fill;
            motor_on    <= w_motor;
            drain_valve <= w_drain;
            door_lock   <= w_lock;
            done        <= w_done;
            fault       <= w_fault;
        end
    end

    assign phase     = r_state;
    assign rinse_cnt = r_rinse;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Bench for wash_cycle_sequencer: cycle-level reference model plus directed program runs.
module tb_wash_cycle_sequencer;

    localparam int TD = 4;
    localparam int RT = 15;
    localparam int FT = 100;
    localparam int DT = 80;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, pause = 1'b0, fault_ack = 1'b0, door_close = 1'b1;
    logic [1:0] prog_sel = 2'd0;
    logic       water_full = 1'b0, water_empty = 1'b0;
    logic       fill_valve, motor_on, drain_valve, door_lock, done, fault;
    logic [2:0] phase;
    logic [1:0] rinse_cnt;

    int checks = 0;
    int failures = 0;

    wash_cycle_sequencer #(
        .TICK_DIV(TD), .RINSE_TICKS(RT), .FILL_TIMEOUT(FT), .DRAIN_TIMEOUT(DT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .fault_ack(fault_ack),
        .door_close(door_close), .prog_sel(prog_sel), .water_full(water_full),
        .water_empty(water_empty), .fill_valve(fill_valve), .motor_on(motor_on),
        .drain_valve(drain_valve), .door_lock(door_lock), .done(done), .fault(fault),
        .phase(phase), .rinse_cnt(rinse_cnt)
    );

    always #5 clk = ~clk;

    // Drum emulation: level sensors assert a set number of cycles into FILL / DRAIN
    int full_delay = 3, empty_delay = 2, fcnt = 0, ecnt = 0;
    always @(negedge clk) begin
        if (phase == 3'd1) begin fcnt++; water_full = (fcnt >= full_delay); end
        else begin fcnt = 0; water_full = 1'b0; end
        if (phase == 3'd3) begin ecnt++; water_empty = (ecnt >= empty_delay); end
        else begin ecnt = 0; water_empty = 1'b0; end
    end

    // Reference model: phases timed in elapsed active cycles (ticks x TICK_DIV)
    int m_ph = 0, m_ret = 0, m_el = 0, m_rinse = 0, m_wash = 0, m_spin = 0, m_nr = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= 0; m_ret <= 0; m_el <= 0; m_rinse <= 0;
            m_wash <= 0; m_spin <= 0; m_nr <= 0;
        end else begin : step
            int ph, el, rn, ret, w, s, nr, dur;
            logic last;
            ph = m_ph; el = m_el; rn = m_rinse; ret = m_ret;
            w = m_wash; s = m_spin; nr = m_nr;
            case (m_ph)
                0: if (start && door_close && prog_sel != 2'd3) begin
                    ph = 1; el = 0; rn = 0;
                    w  = 20 * (int'(prog_sel) + 1);
                    s  = 10 * (int'(prog_sel) + 1);
                    nr = int'(prog_sel) + 1;
                end
                1, 2, 3, 4: begin
                    case (m_ph)
                        1: dur = FT * TD;
                        2: dur = ((rn == 0) ? m_wash : RT) * TD;
                        3: dur = DT * TD;
                        default: dur = m_spin * TD;
                    endcase
                    last = (el + 1 == dur);
                    if (!door_close) begin ph = 7; el = 0; end
                    else if ((m_ph == 1 || m_ph == 3) && last) begin ph = 7; el = 0; end
                    else if (m_ph == 1 && water_full) begin ph = 2; el = 0; end
                    else if (m_ph == 2 && last) begin ph = 3; el = 0; end
                    else if (m_ph == 3 && water_empty) begin
                        if (rn < m_nr) begin rn = rn + 1; ph = 1; end
                        else ph = 4;
                        el = 0;
                    end
                    else if (m_ph == 4 && last) begin ph = 5; el = 0; end
                    else begin
                        el = el + 1;
                        if (pause) begin ret = m_ph; ph = 6; end
                    end
                end
                5: ph = 0;
                6: if (!door_close) ph = 7; else if (!pause) ph = ret;
                default: if (fault_ack) ph = 0;
            endcase
            m_ph <= ph; m_el <= el; m_rinse <= rn; m_ret <= ret;
            m_wash <= w; m_spin <= s; m_nr <= nr;
        end
    end

    function automatic logic [10:0] expv(input int ph, input int rn);
        logic lock;
        lock = (ph != 0) && (ph != 5);
        return {ph == 1, (ph == 2) || (ph == 4), (ph == 3) || (ph == 4), lock,
                ph == 5, ph == 7, 3'(ph), 2'(rn)};
    endfunction

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [10:0] act, req;
        act = {fill_valve, motor_on, drain_valve, door_lock, done, fault, phase, rinse_cnt};
        req = expv(m_ph, m_rinse);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL outputs t=%0t actual=%b required=%b", $time, act, req);
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic wait_phase(input int p, input int budget, output int n);
        n = 0;
        while (int'(phase) != p && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (int'(phase) != p) begin
            failures++;
            $display("FAIL wait_phase_%0d actual=%0d required=%0d", p, phase, p);
        end
    endtask

    initial begin
        int n, act;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({fill_valve, motor_on, drain_valve, door_lock, done, fault,
                                   phase, rinse_cnt}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Quick program, start held through DONE to exercise the restart timing
        prog_sel = 2'd0; start = 1'b1;
        wait_phase(1, 5, n);
        wait_phase(2, 20, n);
        wait_phase(3, 200, n);   chk("quick_wash_len", n, 80);
        wait_phase(1, 50, n);
        wait_phase(2, 20, n);
        wait_phase(3, 200, n);   chk("quick_rinse_len", n, 60);
        wait_phase(4, 20, n);
        wait_phase(5, 200, n);   chk("quick_spin_len", n, 40);
        chk("quick_done", done, 1);
        chk("quick_rinse_cnt", rinse_cnt, 1);
        @(negedge clk);          chk("done_to_idle", phase, 0);
        chk("done_one_cycle", done, 0);
        @(negedge clk);          chk("restart_fill", phase, 1);
        start = 1'b0;
        wait_phase(5, 1000, n);
        wait_phase(0, 5, n);

        // Heavy program; prog_sel change after latch must be ignored
        prog_sel = 2'd2; start = 1'b1;
        wait_phase(1, 5, n);
        start = 1'b0; prog_sel = 2'd0;
        for (int r = 1; r <= 3; r++) begin
            wait_phase(3, 1000, n);
            wait_phase(1, 50, n);
            chk("heavy_rinse_step", rinse_cnt, r);
        end
        wait_phase(3, 1000, n);
        wait_phase(4, 50, n);
        wait_phase(5, 500, n);   chk("heavy_spin_len", n, 120);
        chk("heavy_rinse_final", rinse_cnt, 3);
        wait_phase(0, 5, n);

        // Normal program paused for 50 cycles mid-wash
        prog_sel = 2'd1; start = 1'b1;
        wait_phase(1, 5, n);
        start = 1'b0;
        wait_phase(2, 20, n);
        act = 0; n = 0;
        while (phase != 3'd3 && n < 1000) begin
            if (phase == 3'd2) act++;
            if (n == 30) pause = 1'b1;
            if (n == 31) begin
                chk("pause_phase", phase, 6);
                chk("pause_motor", motor_on, 0);
                chk("pause_lock", door_lock, 1);
            end
            if (n == 80) pause = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("pause_reached_drain", phase, 3);
        chk("agitate_active", act, 160);
        wait_phase(5, 2000, n);
        wait_phase(0, 5, n);

        // Fill timeout: sensor never reports full
        full_delay = 1000000;
        prog_sel = 2'd0; start = 1'b1;
        wait_phase(1, 5, n);
        start = 1'b0;
        wait_phase(7, 1000, n);  chk("fill_timeout_len", n, 400);
        chk("fill_timeout_fault", fault, 1);
        chk("fault_lock", door_lock, 1);
        fault_ack = 1'b1;
        @(negedge clk);
        fault_ack = 1'b0;
        chk("ack_idle", phase, 0);
        chk("ack_unlock", door_lock, 0);
        chk("ack_fault_clr", fault, 0);
        full_delay = 3;

        // Door opens during SPIN together with pause: fault wins
        start = 1'b1;
        wait_phase(1, 5, n);
        start = 1'b0;
        wait_phase(4, 1000, n);
        repeat (5) @(negedge clk);
        door_close = 1'b0; pause = 1'b1;
        @(negedge clk);
        chk("door_fault_phase", phase, 7);
        chk("door_fault_motor", motor_on, 0);
        chk("door_fault_flag", fault, 1);
        door_close = 1'b1; pause = 1'b0; fault_ack = 1'b1;
        @(negedge clk);
        fault_ack = 1'b0;
        chk("door_ack_idle", phase, 0);

        // Invalid program ignored; asynchronous reset during DRAIN
        prog_sel = 2'd3; start = 1'b1;
        repeat (10) @(negedge clk);
        chk("invalid_prog_idle", phase, 0);
        start = 1'b0; prog_sel = 2'd1; empty_delay = 1000000;
        @(negedge clk);
        start = 1'b1;
        wait_phase(1, 5, n);
        start = 1'b0;
        wait_phase(3, 1000, n);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("async_rst_phase", phase, 0);
        chk("async_rst_outputs", int'({fill_valve, motor_on, drain_valve, door_lock, done,
                                       fault, phase, rinse_cnt}), 0);
        @(negedge clk);
        rst = 1'b0; empty_delay = 2;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", phase, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
